// File: rtl/chao_trig_gen.sv
// rtl/chao_trig_gen.sv - ultrasonic trigger generator with programmable period/width, periodic and one-shot modes
module chao_trig_gen #(
    parameter int CNT_W      = 24,
    parameter int MIN_PERIOD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    output logic             trig,
    output logic             tick,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] p_l;
    logic [CNT_W-1:0] w_l;

    logic [CNT_W-1:0] p_clamp;
    logic [CNT_W-1:0] w_clamp;
    logic [CNT_W-1:0] cnt_next;
    logic             at_end;
    logic             do_load;
    logic             do_advance;

    // Clamp the requested period/width and decide what the next edge does:
    // load a fresh period (launch or periodic restart), advance, or drop to idle.
    always_comb begin
        p_clamp    = (period < MIN_P) ? MIN_P : period;
        w_clamp    = (width > (p_clamp - ONE)) ? (p_clamp - ONE) : width;
        cnt_next   = cnt + ONE;
        at_end     = (cnt == (p_l - ONE));
        do_load    = 1'b0;
        do_advance = 1'b0;
        if (state == IDLE) begin
            do_load = en && (!mode || start);
        end else if (en) begin
            do_load    = at_end && !mode;
            do_advance = !at_end;
        end
    end

    // Single state machine with registered trig/tick/busy; anything that is
    // neither a load nor an advance (abort, one-shot end, idle) returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            p_l   <= '0;
            w_l   <= '0;
            trig  <= 1'b0;
            tick  <= 1'b0;
            busy  <= 1'b0;
        end else if (do_load) begin
            state <= RUN;
            cnt   <= '0;
            p_l   <= p_clamp;
            w_l   <= w_clamp;
            trig  <= (w_clamp != '0);
            tick  <= 1'b1;
            busy  <= 1'b1;
        end else if (do_advance) begin
            cnt   <= cnt_next;
            trig  <= (cnt_next < w_l);
            tick  <= 1'b0;
            busy  <= 1'b1;
        end else begin
            state <= IDLE;
            cnt   <= '0;
            trig  <= 1'b0;
            tick  <= 1'b0;
            busy  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chao_trig_gen.sv
// tb/tb_chao_trig_gen.sv - self-checking bench for chao_trig_gen with a period/position reference model
module tb_chao_trig_gen;

    localparam int CNT_W      = 24;
    localparam int MIN_PERIOD = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             mode;
    logic             start;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] width;
    logic             trig;
    logic             tick;
    logic             busy;

    chao_trig_gen #(.CNT_W(CNT_W), .MIN_PERIOD(MIN_PERIOD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .start  (start),
        .period (period),
        .width  (width),
        .trig   (trig),
        .tick   (tick),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_tick   = 0;
    int n_trig   = 0;
    int n_busy   = 0;

    // Reference: a running period is described by its length, high width and
    // the position inside it; outputs follow directly from the position.
    bit m_run = 1'b0;
    int m_pos = 0;
    int m_P   = 0;
    int m_W   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pos = 0;
        m_P   = 0;
        m_W   = 0;
    endtask

    task automatic model_launch();
        m_P   = (int'(period) < MIN_PERIOD) ? MIN_PERIOD : int'(period);
        m_W   = (int'(width) > m_P - 1) ? m_P - 1 : int'(width);
        m_pos = 0;
        m_run = 1'b1;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        @(negedge clk);
        chk("busy", int'(busy), int'(m_run));
        chk("tick", int'(tick), int'(m_run && m_pos == 0));
        chk("trig", int'(trig), int'(m_run && m_pos < m_W));
        n_tick += int'(tick);
        n_trig += int'(trig);
        n_busy += int'(busy);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (!m_run) begin
            if (en && (!mode || start)) model_launch();
        end else if (!en) begin
            m_run = 1'b0;
        end else if (m_pos == m_P - 1) begin
            if (!mode) model_launch();
            else m_run = 1'b0;
        end else begin
            m_pos++;
        end
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) cycle();
    endtask

    // Run n cycles and check hand-computed counts of tick/trig/busy cycles.
    task automatic window(input string name, input int n, input int e_tick,
                          input int e_trig, input int e_busy);
        int b_tick, b_trig, b_busy;
        b_tick = n_tick;
        b_trig = n_trig;
        b_busy = n_busy;
        step(n);
        chk({name, "_ticks"}, n_tick - b_tick, e_tick);
        chk({name, "_trig"},  n_trig - b_trig, e_trig);
        chk({name, "_busy"},  n_busy - b_busy, e_busy);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_trig", int'(trig), 0);
        chk("async_rst_tick", int'(tick), 0);
        chk("async_rst_busy", int'(busy), 0);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int b_tick, b_trig, b_busy;
        rst_n  = 1'b0;
        en     = 1'b0;
        mode   = 1'b0;
        start  = 1'b0;
        period = '0;
        width  = '0;
        step(2);
        chk("reset_trig", int'(trig), 0);
        chk("reset_tick", int'(tick), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;

        // Periodic 10/3
        en = 1'b1; mode = 1'b0; period = 10; width = 3;
        window("periodic", 30, 3, 9, 29);
        en = 1'b0;
        step(2);

        // One-shot 20/5 with an ignored second start
        en = 1'b1; mode = 1'b1; period = 20; width = 5; start = 1'b1;
        b_tick = n_tick; b_trig = n_trig; b_busy = n_busy;
        cycle();
        start = 1'b0;
        step(5);
        start = 1'b1;
        cycle();
        start = 1'b0;
        step(30);
        chk("oneshot_ticks", n_tick - b_tick, 1);
        chk("oneshot_trig",  n_trig - b_trig, 5);
        chk("oneshot_busy",  n_busy - b_busy, 20);

        // Period clamp: 1/4 -> 2/1
        mode = 1'b0; period = 1; width = 4;
        window("clamp", 9, 4, 4, 8);
        en = 1'b0;
        step(2);

        // Zero width, then oversized width
        en = 1'b1; period = 8; width = 0;
        window("w0", 17, 2, 0, 16);
        en = 1'b0;
        step(2);
        en = 1'b1; period = 8; width = 50;
        window("wbig", 17, 2, 14, 16);
        en = 1'b0;
        step(2);

        // Mid-period change of period, then abort at cnt=2
        en = 1'b1; period = 10; width = 3;
        step(5);
        period = 6;
        window("midchg", 13, 2, 4, 13);
        cycle();
        en = 1'b0;
        window("abort", 5, 0, 1, 1);

        // Async reset during the high pulse, then relaunch
        en = 1'b1; period = 10; width = 3;
        step(2);
        chk("pre_rst_trig", int'(trig), 1);
        async_reset();
        cycle();
        chk("relaunch_tick", int'(tick), 1);
        chk("relaunch_busy", int'(busy), 1);
        step(20);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (i % 400 == 200) begin
                async_reset();
            end else begin
                en = ($urandom_range(0, 99) < 95);
                if ($urandom_range(0, 19) == 0) mode = ~mode;
                start  = ($urandom_range(0, 3) == 0);
                period = CNT_W'($urandom_range(0, 12));
                width  = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(13, 40))
                                                     : CNT_W'($urandom_range(0, 12));
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
